// File: rtl/eth_rx_framer_if.sv
// eth_rx_framer_if: framed receive byte stream with end-of-frame status.
// master drives out_valid/out_data/out_sof/out_eof/crc_ok/len_err/frame_len.
interface eth_rx_framer_if;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        crc_ok;
  logic        len_err;
  logic [13:0] frame_len;

  modport master (
    output out_valid, out_data, out_sof, out_eof,
    output crc_ok, len_err, frame_len
  );

  modport slave (
    input out_valid, out_data, out_sof, out_eof,
    input crc_ok, len_err, frame_len
  );
endinterface

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: GMII rx preamble/SFD strip, framing, FCS and length check.
// Ports: clock, reset (async high), rx_dv, rx_data, fr (eth_rx_framer_if
// master: out_* stream + eof status), good_cnt, bad_cnt (saturating).
// Define FCS_STRIP_EN to drop the 4 FCS bytes via a 5-byte delay line.
module eth_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_dv,
  input  logic [7:0]       rx_data,
  eth_rx_framer_if.master  fr,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
);

`ifdef FCS_STRIP_EN
  localparam int DEPTH = 5;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [2:0] FULL = 3'(DEPTH);
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state, state_nx;
  logic [31:0] crc, crc_nx, crc_rev;
  logic [13:0] len, len_inc;
  logic [7:0]  dl [DEPTH];
  logic [2:0]  fill;
  logic        sof_pend;
  logic        start, take, emit, eof, bad;
  logic        crc_ok_w, len_err_w;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    crc_nx  = crc_byte(crc, rx_data);
    len_inc = (len == 14'h3FFF) ? len : len + 14'd1;
    crc_rev = '0;
    // Engine runs reflected; the residue constant is in MSB-first form.
    for (int i = 0; i < 32; i++)
      crc_rev[i] = crc[31-i];
    crc_ok_w  = (crc_rev == RESIDUE);
    len_err_w = (len < 14'(MIN_LEN)) || (len > 14'(MAX_LEN));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    take     = 1'b0;
    emit     = 1'b0;
    eof      = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_dv) begin
          if (rx_data == 8'h55) begin
            state_nx = PRE;
          end else if (rx_data == 8'hD5) begin
            state_nx = DATA;
            start    = 1'b1;
          end else begin
            state_nx = DROP;
          end
        end
      end
      PRE: begin
        if (!rx_dv) begin
          state_nx = IDLE;
          bad      = 1'b1;
        end else if (rx_data == 8'hD5) begin
          state_nx = DATA;
          start    = 1'b1;
        end else if (rx_data != 8'h55) begin
          state_nx = DROP;
        end
      end
      DATA: begin
        if (rx_dv) begin
          take = 1'b1;
          emit = (fill == FULL);
        end else begin
          state_nx = IDLE;
          // Too few bytes to fill the delay line: nothing to deliver.
          if (fill == FULL) begin
            emit = 1'b1;
            eof  = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
      end
      DROP: begin
        if (!rx_dv) begin
          state_nx = IDLE;
          bad      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fr.out_valid <= 1'b0;
      fr.out_data  <= 8'h00;
      fr.out_sof   <= 1'b0;
      fr.out_eof   <= 1'b0;
      fr.crc_ok    <= 1'b0;
      fr.len_err   <= 1'b0;
      fr.frame_len <= 14'h0;
      good_cnt     <= 16'h0;
      bad_cnt      <= 16'h0;
      crc          <= 32'hFFFFFFFF;
      len          <= 14'h0;
      fill         <= 3'd0;
      sof_pend     <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        dl[i] <= 8'h00;
    end else begin
      fr.out_valid <= emit;
      fr.out_data  <= emit ? dl[DEPTH-1] : 8'h00;
      fr.out_sof   <= emit & sof_pend;
      fr.out_eof   <= eof;
      fr.crc_ok    <= eof & crc_ok_w;
      fr.len_err   <= eof & len_err_w;
      fr.frame_len <= eof ? len : 14'h0;
      if (start) begin
        crc      <= 32'hFFFFFFFF;
        len      <= 14'h0;
        fill     <= 3'd0;
        sof_pend <= 1'b1;
      end
      if (take) begin
        crc   <= crc_nx;
        len   <= len_inc;
        dl[0] <= rx_data;
        for (int i = 1; i < DEPTH; i++)
          dl[i] <= dl[i-1];
        if (fill != FULL)
          fill <= fill + 3'd1;
      end
      if (emit)
        sof_pend <= 1'b0;
      if (eof && crc_ok_w && !len_err_w) begin
        if (good_cnt != 16'hFFFF)
          good_cnt <= good_cnt + 16'd1;
      end else if (eof || bad) begin
        if (bad_cnt != 16'hFFFF)
          bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end

endmodule
